alu_seq_divider: RTL

//  Multi-cycle unsigned restoring divider that serves the ALU's divide function (alu_func 4'b1000).
//  The ALU issues a request on start and consumes the result on done.

---
 rtl/alu_seq_divider_if.sv | 23 ++
 rtl/alu_seq_divider.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_seq_divider_if.sv
// Request/result bundle between the ALU divide path and the sequential divider.
interface alu_seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero short-circuits straight to DONE with q = all ones, r = dividend.
module alu_seq_divider #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    alu_seq_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] dvd_reg, dvd_next;
    logic [WIDTH-1:0] dsr_reg, dsr_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             div_zero_reg, div_zero_next;

    // Shifted partial remainder keeps its carry bit so the compare is exact
    // when the divisor MSB is set; after a subtract the result always fits WIDTH.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_diff;
    logic             q_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            count_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            dvd_reg       <= dvd_next;
            dsr_reg       <= dsr_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            count_reg     <= count_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            div_zero_reg  <= div_zero_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        dvd_next       = dvd_reg;
        dsr_next       = dsr_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        count_next     = count_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        div_zero_next  = div_zero_reg;

        r_shift = {rem_reg, dvd_reg[WIDTH-1]};
        r_diff  = r_shift[WIDTH-1:0] - dsr_reg;
        q_bit   = (r_shift >= {1'b0, dsr_reg});

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        dvd_next   = bus.dividend;
                        dsr_next   = bus.divisor;
                        rem_next   = '0;
                        quo_next   = '0;
                        count_next = '0;
                        state_next = CALC;
                    end else begin
                        quotient_next  = '1;
                        remainder_next = bus.dividend;
                        div_zero_next  = 1'b1;
                        state_next     = DONE;
                    end
                end
            end
            CALC: begin
                rem_next   = q_bit ? r_diff : r_shift[WIDTH-1:0];
                quo_next   = {quo_reg[WIDTH-2:0], q_bit};
                dvd_next   = {dvd_reg[WIDTH-2:0], 1'b0};
                count_next = count_reg + 1'b1;
                if (count_reg == LAST_COUNT) begin
                    quotient_next  = {quo_reg[WIDTH-2:0], q_bit};
                    remainder_next = q_bit ? r_diff : r_shift[WIDTH-1:0];
                    div_zero_next  = 1'b0;
                    count_next     = '0;
                    state_next     = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_reg == CALC);
    assign bus.done      = (state_reg == DONE);
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.div_zero  = div_zero_reg;
endmodule
